// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: mode encoding and width helpers.
package spi_pkg;

  // SPI mode as {CPOL, CPHA}.
  typedef enum logic [1:0] {
    SPI_MODE0 = 2'b00,
    SPI_MODE1 = 2'b01,
    SPI_MODE2 = 2'b10,
    SPI_MODE3 = 2'b11
  } spi_mode_e;

  // Ceiling log2 for elaboration-time widths.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Bit-counter width for a given word width (at least one bit).
  function automatic int unsigned bit_w(input int unsigned word_w);
    return (word_w < 2) ? 1 : clog2(word_w);
  endfunction

  // Modes 1 and 2 sample on the falling Sclk edge, so the internal clock is inverted.
  function automatic logic edge_invert(input spi_mode_e mode);
    return (mode == SPI_MODE1) || (mode == SPI_MODE2);
  endfunction

endpackage

// File: rtl/spi_bit_cnt.sv
// Modulo-MOD counter with asynchronous reset/clear and a terminal-count flag.
module spi_bit_cnt #(
  parameter int unsigned MOD = 8,
  parameter int unsigned W   = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         last
);

  assign last = (cnt == W'(MOD - 1));

  // Wrap explicitly at MOD-1 so non-power-of-two moduli work.
  always_ff @(posedge clk or negedge rst or posedge clr) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/spi_slave_burst.sv
// SPI slave with selectable mode, bit order and word width, supporting
// multi-word bursts within one Cs-low frame. Clocked only by Sclk.
module spi_slave_burst
  import spi_pkg::*;
#(
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned BIT_W     = bit_w(WORD_W),
  parameter int unsigned WCNT_W    = 4,
  parameter logic        CPOL      = 1'b0,
  parameter logic        CPHA      = 1'b0,
  parameter logic        LSB_FIRST = 1'b1
) (
  input  logic              Sclk,
  input  logic              rst,
  input  logic              Cs,
  input  logic              Mosi,
  input  logic [WORD_W-1:0] d_in,
  output logic              Miso,
  output logic [WORD_W-1:0] d_rec,
  output logic              rx_tgl,
  output logic              tx_tgl,
  output logic [WCNT_W-1:0] words_rx
);

  localparam spi_mode_e        MODE = spi_mode_e'({CPOL, CPHA});
  localparam logic             INV  = edge_invert(MODE);
  localparam logic [BIT_W-1:0] LAST = BIT_W'(WORD_W - 1);

  logic              sclk_i;
  logic              sclk_n;
  logic [BIT_W-1:0]  rx_bit;
  logic              rx_last;
  logic [BIT_W-1:0]  tx_idx;
  logic              tx_last;
  logic [BIT_W-1:0]  tx_nxt;
  logic [BIT_W-1:0]  tx_k;
  logic              tx_cap;
  logic              started;
  logic [WORD_W-1:0] rx_shift;
  logic [WORD_W-1:0] rx_word;
  logic [WORD_W-1:0] tx_hold;

  function automatic logic [BIT_W-1:0] pos(input logic [BIT_W-1:0] k);
    return LSB_FIRST ? k : LAST - k;
  endfunction

  // Sample on posedge sclk_i, drive on negedge sclk_i, for every mode.
  assign sclk_i = Sclk ^ INV;
  assign sclk_n = ~sclk_i;

  spi_bit_cnt #(.MOD(WORD_W), .W(BIT_W)) u_rx_cnt (
    .clk  (sclk_i),
    .rst  (rst),
    .clr  (Cs),
    .en   (1'b1),
    .cnt  (rx_bit),
    .last (rx_last)
  );

  spi_bit_cnt #(.MOD(WORD_W), .W(BIT_W)) u_tx_cnt (
    .clk  (sclk_n),
    .rst  (rst),
    .clr  (Cs),
    .en   (1'b1),
    .cnt  (tx_idx),
    .last (tx_last)
  );

  // Current word with the incoming Mosi bit merged at its position.
  always_comb begin
    rx_word              = rx_shift;
    rx_word[pos(rx_bit)] = Mosi;
  end

  // Frame-scoped receive state: cleared by reset or by Cs going high.
  always_ff @(posedge sclk_i or negedge rst or posedge Cs) begin
    if (!rst) begin
      rx_shift <= '0;
      words_rx <= '0;
    end else if (Cs) begin
      rx_shift <= '0;
      words_rx <= '0;
    end else begin
      rx_shift <= rx_word;
      if (rx_last && (words_rx != '1)) words_rx <= words_rx + WCNT_W'(1);
    end
  end

  // Completed-word outputs survive Cs and clear only on reset.
  always_ff @(posedge sclk_i or negedge rst) begin
    if (!rst) begin
      d_rec  <= '0;
      rx_tgl <= 1'b0;
    end else if (!Cs && rx_last) begin
      d_rec  <= rx_word;
      rx_tgl <= ~rx_tgl;
    end
  end

  // Slot k after this drive edge is the new tx_idx (CPHA=0) or the old one (CPHA=1).
  always_comb begin
    tx_nxt = tx_last ? '0 : tx_idx + BIT_W'(1);
    tx_cap = ((CPHA ? tx_idx : tx_nxt) == BIT_W'(1));
    tx_k   = CPHA ? ((tx_idx == '0) ? LAST : tx_idx - BIT_W'(1)) : tx_idx;
  end

  // Marks that the first drive edge of the frame has occurred.
  always_ff @(negedge sclk_i or negedge rst or posedge Cs) begin
    if (!rst) begin
      started <= 1'b0;
    end else if (Cs) begin
      started <= 1'b0;
    end else begin
      started <= 1'b1;
    end
  end

  // Capture the transmit word once its first bit has gone out directly from d_in.
  always_ff @(negedge sclk_i or negedge rst) begin
    if (!rst) begin
      tx_hold <= '0;
      tx_tgl  <= 1'b0;
    end else if (!Cs && tx_cap) begin
      tx_hold <= d_in;
      tx_tgl  <= ~tx_tgl;
    end
  end

  // Slot 0 comes straight from d_in; later slots from the held copy.
  always_comb begin
    Miso = 1'b0;
    if (rst && !Cs && (!CPHA || started)) begin
      Miso = (tx_k == '0) ? d_in[pos('0)] : tx_hold[pos(tx_k)];
    end
  end

endmodule

// File: tb/tb_spi_slave_burst.sv
// Bench for spi_slave_burst: three instances (mode 0 LSB-first 8-bit,
// mode 3 MSB-first 8-bit, mode 1 LSB-first 12-bit) driven by a bit-level master.
module tb_spi_slave_burst;

  localparam int WW     [3] = '{8, 8, 12};
  localparam bit CPOL_C [3] = '{1'b0, 1'b1, 1'b0};
  localparam bit CPHA_C [3] = '{1'b0, 1'b1, 1'b1};
  localparam bit LSB_C  [3] = '{1'b1, 1'b0, 1'b1};
  localparam int WMAX = 15;

  logic        rst;
  logic        sclk [3];
  logic        cs   [3];
  logic        mosi [3];
  logic        miso [3];
  logic        rxt  [3];
  logic        txt  [3];
  logic [7:0]  din0, din1, drec0, drec1;
  logic [11:0] din2, drec2;
  logic [3:0]  wrx0, wrx1, wrx2;

  int checks   = 0;
  int failures = 0;

  logic [15:0] tx_w [32];
  logic [15:0] rx_w [32];
  logic [15:0] m_drec [3];
  logic        m_rxt  [3];
  logic        m_txt  [3];
  int          m_wrx  [3];
  logic [15:0] seq;

  spi_slave_burst #(.WORD_W(8), .WCNT_W(4), .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b1)) u_dut0 (
    .Sclk(sclk[0]), .rst(rst), .Cs(cs[0]), .Mosi(mosi[0]), .d_in(din0), .Miso(miso[0]),
    .d_rec(drec0), .rx_tgl(rxt[0]), .tx_tgl(txt[0]), .words_rx(wrx0)
  );

  spi_slave_burst #(.WORD_W(8), .WCNT_W(4), .CPOL(1'b1), .CPHA(1'b1), .LSB_FIRST(1'b0)) u_dut1 (
    .Sclk(sclk[1]), .rst(rst), .Cs(cs[1]), .Mosi(mosi[1]), .d_in(din1), .Miso(miso[1]),
    .d_rec(drec1), .rx_tgl(rxt[1]), .tx_tgl(txt[1]), .words_rx(wrx1)
  );

  spi_slave_burst #(.WORD_W(12), .BIT_W(4), .WCNT_W(4), .CPOL(1'b0), .CPHA(1'b1), .LSB_FIRST(1'b1)) u_dut2 (
    .Sclk(sclk[2]), .rst(rst), .Cs(cs[2]), .Mosi(mosi[2]), .d_in(din2), .Miso(miso[2]),
    .d_rec(drec2), .rx_tgl(rxt[2]), .tx_tgl(txt[2]), .words_rx(wrx2)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] drec_of(input int s);
    case (s)
      0:       return {8'h00, drec0};
      1:       return {8'h00, drec1};
      default: return {4'h0, drec2};
    endcase
  endfunction

  function automatic logic [15:0] wrx_of(input int s);
    case (s)
      0:       return {12'h000, wrx0};
      1:       return {12'h000, wrx1};
      default: return {12'h000, wrx2};
    endcase
  endfunction

  task automatic set_din(input int s, input logic [15:0] v);
    case (s)
      0:       din0 = v[7:0];
      1:       din1 = v[7:0];
      default: din2 = v[11:0];
    endcase
  endtask

  task automatic check_rx(input int s, input string tag);
    check({tag, "_drec"}, drec_of(s), m_drec[s]);
    check({tag, "_rxt"}, 16'(rxt[s]), 16'(m_rxt[s]));
    check({tag, "_wrx"}, wrx_of(s), 16'(m_wrx[s]));
  endtask

  // One bit slot: drive edge (if leading), Mosi setup, Miso check, sample edge, rx check.
  task automatic send_bit(input int s, input logic [15:0] txv, input logic [15:0] rxv,
                          input int j, input bit last);
    int p;
    p = LSB_C[s] ? j : WW[s] - 1 - j;
    if (CPHA_C[s]) begin
      sclk[s] = !CPOL_C[s];
      #2;
    end
    mosi[s] = rxv[p];
    #3;
    check("miso_bit", 16'(miso[s]), 16'(txv[p]));
    seq = {seq[14:0], miso[s]};
    sclk[s] = CPHA_C[s] ? CPOL_C[s] : !CPOL_C[s];
    #1;
    if (last) begin
      m_drec[s] = rxv;
      m_rxt[s]  = !m_rxt[s];
      if (m_wrx[s] < WMAX) m_wrx[s]++;
    end
    check_rx(s, "rx");
    #4;
    if (!CPHA_C[s]) begin
      sclk[s] = CPOL_C[s];
      #2;
    end
  endtask

  // n full words back to back, then `part` bits of word n (part must be 0 or >= 3).
  task automatic run_words(input int s, input int n, input int part);
    int nb;
    for (int w = 0; w <= n; w++) begin
      nb = (w < n) ? WW[s] : part;
      if (nb == 0) break;
      seq = '0;
      for (int j = 0; j < nb; j++) begin
        if (j == 2) begin
          m_txt[s] = !m_txt[s];
          check("tx_tgl", 16'(txt[s]), 16'(m_txt[s]));
          set_din(s, tx_w[w + 1]);
        end
        send_bit(s, tx_w[w], rx_w[w], j, j == WW[s] - 1);
      end
    end
  endtask

  task automatic start_frame(input int s);
    set_din(s, tx_w[0]);
    cs[s] = 1'b0;
    #5;
  endtask

  task automatic end_frame(input int s);
    cs[s] = 1'b1;
    #1;
    m_wrx[s] = 0;
    check("idle_miso", 16'(miso[s]), 16'h0);
    check("idle_txt", 16'(txt[s]), 16'(m_txt[s]));
    check_rx(s, "idle");
    #5;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      m_drec[s] = '0;
      m_rxt[s]  = 1'b0;
      m_txt[s]  = 1'b0;
      m_wrx[s]  = 0;
      check("rst_miso", 16'(miso[s]), 16'h0);
      check("rst_txt", 16'(txt[s]), 16'h0);
      check_rx(s, "rst");
    end
    #4;
    rst = 1'b1;
    #5;
  endtask

  initial begin
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sclk[s] = CPOL_C[s];
      cs[s]   = 1'b1;
      mosi[s] = 1'b0;
    end
    din0 = '0;
    din1 = '0;
    din2 = '0;
    seq  = '0;
    #5;
    do_reset();

    // Mode 0, LSB first: send 0x3C, return 0xA5
    tx_w[0] = 16'h00A5; tx_w[1] = 16'h0000; rx_w[0] = 16'h003C;
    start_frame(0);
    run_words(0, 1, 0);
    check("t1_seq", seq, 16'h00A5);
    check("t1_drec", drec_of(0), 16'h003C);
    check("t1_rxt", 16'(rxt[0]), 16'h0001);
    check("t1_wrx", wrx_of(0), 16'h0001);
    end_frame(0);

    // Mode 3, MSB first: send 0x81, return 0xC3
    tx_w[0] = 16'h00C3; tx_w[1] = 16'h0000; rx_w[0] = 16'h0081;
    start_frame(1);
    run_words(1, 1, 0);
    check("t2_seq", seq, 16'h00C3);
    check("t2_drec", drec_of(1), 16'h0081);
    check("t2_wrx", wrx_of(1), 16'h0001);
    end_frame(1);

    // Three-word burst in mode 0
    tx_w[0] = 16'h00AA; tx_w[1] = 16'h0055; tx_w[2] = 16'h00F0; tx_w[3] = 16'h0000;
    rx_w[0] = 16'h0011; rx_w[1] = 16'h0022; rx_w[2] = 16'h0033;
    start_frame(0);
    run_words(0, 3, 0);
    check("t3_seq", seq, 16'h000F);
    check("t3_drec", drec_of(0), 16'h0033);
    check("t3_rxt", 16'(rxt[0]), 16'h0000);
    check("t3_wrx", wrx_of(0), 16'h0003);
    end_frame(0);

    // Cs raised after 5 bits of a second word
    tx_w[0] = 16'h005A; tx_w[1] = 16'h003C; tx_w[2] = 16'h0000;
    rx_w[0] = 16'h0012; rx_w[1] = 16'h00FF;
    start_frame(1);
    run_words(1, 1, 5);
    check("t4_wrx_mid", wrx_of(1), 16'h0001);
    end_frame(1);
    check("t4_drec_kept", drec_of(1), 16'h0012);
    check("t4_rxt_kept", 16'(rxt[1]), 16'h0000);
    tx_w[0] = 16'h0096; tx_w[1] = 16'h0000; rx_w[0] = 16'h0034;
    start_frame(1);
    run_words(1, 1, 0);
    check("t4_drec_new", drec_of(1), 16'h0034);
    check("t4_wrx_new", wrx_of(1), 16'h0001);
    end_frame(1);

    // Reset at bit 4 of a frame, then a clean frame
    tx_w[0] = 16'h000F; tx_w[1] = 16'h0000; rx_w[0] = 16'h00FF;
    start_frame(0);
    run_words(0, 0, 4);
    do_reset();
    end_frame(0);
    tx_w[0] = 16'h003C; tx_w[1] = 16'h0000; rx_w[0] = 16'h005A;
    start_frame(0);
    run_words(0, 1, 0);
    check("t5_drec", drec_of(0), 16'h005A);
    check("t5_wrx", wrx_of(0), 16'h0001);
    end_frame(0);

    // 12-bit mode 1, 20 words: word counter saturates
    for (int i = 0; i < 21; i++) begin
      tx_w[i] = 16'((i * 695 + 421) % 4096);
      rx_w[i] = 16'((i * 961 + 243) % 4096);
    end
    start_frame(2);
    run_words(2, 20, 0);
    check("t6_wrx_sat", wrx_of(2), 16'h000F);
    check("t6_rxt", 16'(rxt[2]), 16'h0000);
    check("t6_drec", drec_of(2), rx_w[19]);
    end_frame(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
